grid_clb_param: RTL and testbench

- Parametrised successor to the fixed logic tile.
- Holds N_BLE basic logic elements (BLEs). Each BLE has a K-input LUT, an optional registered output, and a per-input crossbar that selects from tile inputs, BLE feedback, or constant 0.
- Configuration is loaded through an on-tile shift chain (ccff_head to ccff_tail) on the same clock.
- A bit counter tracks load progress. Tile outputs stay at 0 until a complete bitstream has been shifted in.

---
 rtl/clb_pkg.sv | 29 ++
 rtl/clb_ble.sv | 50 +++++
 rtl/grid_clb_param.sv | 74 +++++++
 tb/tb_grid_clb_param.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/clb_pkg.sv
// Shared constants and helpers for the parametrised logic tile.
package clb_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int unsigned LUT_OFS = 0;

    function automatic int unsigned sel_ofs(input int unsigned k, input int unsigned sel_w,
                                            input int unsigned j);
        return (32'd1 << k) + j * sel_w;
    endfunction

    function automatic int unsigned ffen_ofs(input int unsigned k, input int unsigned sel_w);
        return (32'd1 << k) + k * sel_w;
    endfunction

    // Lowest select value that decodes to constant 0; every value above it does too.
    function automatic int unsigned sel_const0(input int unsigned n_in, input int unsigned n_ble);
        return n_in + n_ble;
    endfunction

endpackage

// File: rtl/clb_ble.sv
// One basic logic element: K crossbar muxes, a K-input LUT and a bypassable flip-flop.
module clb_ble
    import clb_pkg::*;
#(
    parameter int unsigned N_IN     = 12,
    parameter int unsigned N_BLE    = 8,
    parameter int unsigned K        = 4,
    parameter int unsigned SEL_W    = clog2(N_IN + N_BLE + 1),
    parameter int unsigned BLE_BITS = ffen_ofs(K, SEL_W) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic [BLE_BITS-1:0]     cfg,
    input  logic [N_IN+N_BLE-1:0]   cand,
    output logic                    ble_out_c
);

    localparam int unsigned N_SEL = 2 ** SEL_W;
    localparam int unsigned FFEN  = ffen_ofs(K, SEL_W);

    logic [N_SEL-1:0] cand_ext;
    logic [2**K-1:0]  truth;
    logic [K-1:0]     lut_in;
    logic             lut_out;
    logic             ff_d;
    logic             ff_q;

    // Zero-extending the candidates makes every select at or above sel_const0 read 0.
    always_comb begin
        cand_ext = N_SEL'(cand);
        truth    = cfg[LUT_OFS +: 2**K];
        lut_in   = '0;
        for (int unsigned j = 0; j < K; j++) begin
            lut_in[j] = cand_ext[cfg[sel_ofs(K, SEL_W, j) +: SEL_W]];
        end
        lut_out   = truth[lut_in];
        ff_d      = run ? lut_out : 1'b0;
        ble_out_c = cfg[FFEN] ? ff_q : lut_out;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ff_q <= 1'b0;
        end else begin
            ff_q <= ff_d;
        end
    end

endmodule

// File: rtl/grid_clb_param.sv
// Parametrised logic tile: serial configuration chain, load counter and N_BLE logic elements.
module grid_clb_param
    import clb_pkg::*;
#(
    parameter int unsigned N_IN  = 12,
    parameter int unsigned N_BLE = 8,
    parameter int unsigned K     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_en,
    input  logic             ccff_head,
    input  logic [N_IN-1:0]  clb_I,
    output logic [N_BLE-1:0] clb_O,
    output logic             ccff_tail,
    output logic             cfg_done
);

    localparam int unsigned SEL_W    = clog2(N_IN + N_BLE + 1);
    localparam int unsigned BLE_BITS = ffen_ofs(K, SEL_W) + 1;
    localparam int unsigned CFG_BITS = N_BLE * BLE_BITS;
    localparam int unsigned CNT_W    = clog2(CFG_BITS + 1);

    logic [CFG_BITS-1:0] cfg_d;
    logic [CFG_BITS-1:0] cfg_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [N_BLE-1:0]    ble_out;
    logic                run;

    // A shift while loaded restarts the count at 1, so the counter never passes CFG_BITS.
    always_comb begin
        cfg_d = cfg_q;
        cnt_d = cnt_q;
        if (cfg_en) begin
            cfg_d = {cfg_q[CFG_BITS-2:0], ccff_head};
            cnt_d = cfg_done ? CNT_W'(1) : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_q <= '0;
            cnt_q <= '0;
        end else begin
            cfg_q <= cfg_d;
            cnt_q <= cnt_d;
        end
    end

    assign cfg_done  = (cnt_q == CNT_W'(CFG_BITS));
    assign run       = cfg_done & ~cfg_en;
    assign ccff_tail = cfg_q[CFG_BITS-1];
    assign clb_O     = cfg_done ? ble_out : '0;

    // Feedback taps the gated outputs so a half-shifted bitstream can never close a live loop.
    for (genvar b = 0; b < N_BLE; b++) begin : g_ble
        clb_ble #(
            .N_IN    (N_IN),
            .N_BLE   (N_BLE),
            .K       (K),
            .SEL_W   (SEL_W),
            .BLE_BITS(BLE_BITS)
        ) u_ble (
            .clk      (clk),
            .reset    (reset),
            .run      (run),
            .cfg      (cfg_q[b*BLE_BITS +: BLE_BITS]),
            .cand     ({clb_O, clb_I}),
            .ble_out_c(ble_out[b])
        );
    end

endmodule

// File: tb/tb_grid_clb_param.sv
// Randomised and directed bench for grid_clb_param against a bit-level behavioural model.
module tb_grid_clb_param;

    localparam int N_IN     = 12;
    localparam int N_BLE    = 8;
    localparam int K        = 4;
    localparam int SEL_W    = 5;
    localparam int N_LUT    = 16;
    localparam int BLE_BITS = N_LUT + K * SEL_W + 1;
    localparam int CFG_BITS = N_BLE * BLE_BITS;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_en;
    logic              ccff_head;
    logic [N_IN-1:0]   clb_I;
    logic [N_BLE-1:0]  clb_O;
    logic              ccff_tail;
    logic              cfg_done;

    int checks = 0;
    int errors = 0;

    logic [CFG_BITS-1:0] m_cfg;
    int                  m_cnt;
    logic [N_BLE-1:0]    m_ff;

    always #5 clk = ~clk;

    grid_clb_param dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_en   (cfg_en),
        .ccff_head(ccff_head),
        .clb_I    (clb_I),
        .clb_O    (clb_O),
        .ccff_tail(ccff_tail),
        .cfg_done (cfg_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Evaluate every BLE, iterating until combinational chains settle.
    function automatic void m_eval(input logic [N_IN-1:0] pins,
                                   output logic [N_BLE-1:0] luts,
                                   output logic [N_BLE-1:0] bo);
        logic [BLE_BITS-1:0] f;
        int v;
        int idx;
        bo   = m_ff;
        luts = '0;
        for (int pass = 0; pass <= N_BLE; pass++) begin
            for (int b = 0; b < N_BLE; b++) begin
                f   = m_cfg[b*BLE_BITS +: BLE_BITS];
                idx = 0;
                for (int j = 0; j < K; j++) begin
                    v = int'(f[N_LUT + j*SEL_W +: SEL_W]);
                    if (v < N_IN)             idx += int'(pins[v]) << j;
                    else if (v < N_IN + N_BLE) idx += int'(bo[v - N_IN]) << j;
                end
                luts[b] = f[idx];
                bo[b]   = f[BLE_BITS-1] ? m_ff[b] : luts[b];
            end
        end
    endfunction

    function automatic logic [N_BLE-1:0] m_out(input logic [N_IN-1:0] pins);
        logic [N_BLE-1:0] luts;
        logic [N_BLE-1:0] bo;
        m_eval(pins, luts, bo);
        return (m_cnt == CFG_BITS) ? bo : '0;
    endfunction

    task automatic m_clock();
        logic [N_BLE-1:0] luts;
        logic [N_BLE-1:0] bo;
        bit done;
        if (reset) begin
            m_cfg = '0;
            m_cnt = 0;
            m_ff  = '0;
        end else begin
            done = (m_cnt == CFG_BITS);
            m_eval(clb_I, luts, bo);
            m_ff = (done && !cfg_en) ? luts : '0;
            if (cfg_en) begin
                m_cfg = {m_cfg[CFG_BITS-2:0], ccff_head};
                m_cnt = done ? 1 : m_cnt + 1;
            end
        end
    endtask

    // Clock the previous inputs into the model, then apply new ones and compare.
    task automatic step(input bit rst, input bit en, input bit head, input logic [N_IN-1:0] pins);
        @(posedge clk);
        m_clock();
        @(negedge clk);
        reset     = rst;
        cfg_en    = en;
        ccff_head = head;
        clb_I     = pins;
        #1;
        chk("clb_O", 32'(clb_O), 32'(m_out(clb_I)));
        chk("cfg_done", 32'(cfg_done), 32'(m_cnt == CFG_BITS));
        chk("ccff_tail", 32'(ccff_tail), 32'(m_cfg[CFG_BITS-1]));
    endtask

    task automatic load(input logic [CFG_BITS-1:0] bs, input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 1, bs[CFG_BITS-1-i], N_IN'($urandom));
        end
    endtask

    function automatic logic [BLE_BITS-1:0] mk_ble(input logic [15:0] lut, input int s0, input int s1,
                                                   input int s2, input int s3, input bit ffen);
        logic [BLE_BITS-1:0] f;
        f                         = '0;
        f[N_LUT-1:0]              = lut;
        f[N_LUT + 0*SEL_W +: SEL_W] = SEL_W'(s0);
        f[N_LUT + 1*SEL_W +: SEL_W] = SEL_W'(s1);
        f[N_LUT + 2*SEL_W +: SEL_W] = SEL_W'(s2);
        f[N_LUT + 3*SEL_W +: SEL_W] = SEL_W'(s3);
        f[BLE_BITS-1]             = ffen;
        return f;
    endfunction

    // Legal random bitstream: feedback only from registered BLEs.
    function automatic logic [CFG_BITS-1:0] rand_bs();
        logic [CFG_BITS-1:0] bs;
        logic [N_BLE-1:0]    ffen;
        int s[K];
        ffen = N_BLE'($urandom);
        for (int b = 0; b < N_BLE; b++) begin
            for (int j = 0; j < K; j++) begin
                s[j] = int'($urandom_range(0, 31));
                if (s[j] >= N_IN && s[j] < N_IN + N_BLE && !ffen[s[j] - N_IN])
                    s[j] = int'($urandom_range(0, N_IN - 1));
            end
            bs[b*BLE_BITS +: BLE_BITS] = mk_ble(16'($urandom), s[0], s[1], s[2], s[3], ffen[b]);
        end
        return bs;
    endfunction

    logic [CFG_BITS-1:0] ones_bs;
    logic [CFG_BITS-1:0] dir_bs;

    initial begin
        reset = 1'b1; cfg_en = 1'b0; ccff_head = 1'b0; clb_I = '0;
        m_cfg = '0; m_cnt = 0; m_ff = '0;

        // Reset state, inputs high while unconfigured
        step(1, 0, 0, 12'hFFF);
        step(1, 0, 0, 12'hFFF);
        chk("rst_clb_O", 32'(clb_O), 32'h0);
        chk("rst_done", 32'(cfg_done), 32'h0);
        chk("rst_tail", 32'(ccff_tail), 32'h0);
        step(0, 0, 0, 12'hFFF);
        chk("unconf_clb_O", 32'(clb_O), 32'h0);

        // All-ones load, then a marker bit followed by zeros
        ones_bs = '1;
        load(ones_bs, CFG_BITS);
        chk("done_before_last_edge", 32'(cfg_done), 32'h0);
        step(0, 1, 1, 12'h000);
        chk("done_after_296", 32'(cfg_done), 32'h1);
        for (int i = 0; i < CFG_BITS - 1; i++) step(0, 1, 0, N_IN'($urandom));
        step(0, 1, 0, 12'h000);
        chk("marker_tail", 32'(ccff_tail), 32'h1);
        chk("reload_done", 32'(cfg_done), 32'h1);
        step(0, 0, 0, 12'h000);
        chk("marker_gone", 32'(ccff_tail), 32'h0);
        chk("reload_restart", 32'(cfg_done), 32'h0);

        // AND gate on BLE0, self-toggling register on BLE1
        dir_bs = '0;
        for (int b = 0; b < N_BLE; b++) dir_bs[b*BLE_BITS +: BLE_BITS] = mk_ble(16'h0000, 31, 31, 31, 31, 0);
        dir_bs[0*BLE_BITS +: BLE_BITS] = mk_ble(16'h0008, 0, 1, 31, 31, 0);
        dir_bs[1*BLE_BITS +: BLE_BITS] = mk_ble(16'h0001, 13, 31, 31, 31, 1);
        step(1, 0, 0, 12'h000);
        load(dir_bs, CFG_BITS);
        step(0, 0, 0, 12'h003);
        chk("and_11", 32'(clb_O[0]), 32'h1);
        chk("tog0", 32'(clb_O[1]), 32'h0);
        step(0, 0, 0, 12'h001);
        chk("and_01", 32'(clb_O[0]), 32'h0);
        chk("tog1", 32'(clb_O[1]), 32'h1);
        step(0, 0, 0, 12'h002);
        chk("and_10", 32'(clb_O[0]), 32'h0);
        chk("tog2", 32'(clb_O[1]), 32'h0);
        step(0, 0, 0, 12'h003);
        chk("tog3", 32'(clb_O[1]), 32'h1);

        // Reconfigure pulse while running, then reset mid-shift (reset beats cfg_en)
        step(0, 1, 0, 12'h003);
        step(0, 0, 0, 12'h003);
        chk("pulse_done", 32'(cfg_done), 32'h0);
        chk("pulse_clb_O", 32'(clb_O), 32'h0);
        load(ones_bs, 149);
        step(1, 1, 1, 12'h003);
        step(0, 0, 0, 12'h003);
        chk("midrst_done", 32'(cfg_done), 32'h0);
        chk("midrst_tail", 32'(ccff_tail), 32'h0);

        // Partial load of 295 bits, then the last one
        load(dir_bs, CFG_BITS - 1);
        step(0, 0, 0, 12'h003);
        chk("partial_done", 32'(cfg_done), 32'h0);
        chk("partial_clb_O", 32'(clb_O), 32'h0);
        step(0, 1, dir_bs[0], 12'h003);
        step(0, 0, 0, 12'h003);
        chk("full_done", 32'(cfg_done), 32'h1);
        chk("full_and", 32'(clb_O[0]), 32'h1);

        // Random legal bitstreams with random pins, reconfig pulses and resets
        for (int it = 0; it < 8; it++) begin
            step(1, 0, 0, N_IN'($urandom));
            load(rand_bs(), CFG_BITS);
            for (int c = 0; c < 60; c++) begin
                step(($urandom_range(0, 49) == 0), ($urandom_range(0, 24) == 0),
                     1'($urandom), N_IN'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
